// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM states, digit positions and per-position digit limits
package stopwatch_pkg;
  typedef enum logic [1:0] {RUN, PAUSE, ADJUST, CLEAR} state_t;
  localparam logic [1:0] POS_SEC_ONES = 2'd0;
  localparam logic [1:0] POS_SEC_TENS = 2'd1;
  localparam logic [1:0] POS_MIN_ONES = 2'd2;
  localparam logic [1:0] POS_MIN_TENS = 2'd3;
  localparam logic [2:0] ADJ_SEL_NONE = 3'd5;
  localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
  localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;
  function automatic logic [3:0] max_digit(input logic [1:0] pos);
    return (pos == POS_SEC_TENS || pos == POS_MIN_TENS) ? DIGIT_MAX_TENS : DIGIT_MAX_ONES;
  endfunction
  function automatic logic [3:0] clamp_digit(input logic [1:0] pos, input logic [3:0] v);
    return (v > max_digit(pos)) ? max_digit(pos) : v;
  endfunction
endpackage

// File: rtl/stopwatch_ctrl_edge_rise.sv
// edge_rise: rising-edge detector (clk, rst_n, d -> rise); history resets to 1 so a level held through reset is not an edge
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk)
    if (!rst_n) prev <= 1'b1;
    else prev <= d;
  assign rise = d & ~prev;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust/clear FSM (buttons, adj_sw, sel, num -> cnt_rst, paused, adj_en/sel/val/wr, blink_on)
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_reset,
  input  logic       btn_pause,
  input  logic       adj_sw,
  input  logic [1:0] sel,
  input  logic [3:0] num,
  output logic       cnt_rst,
  output logic       paused,
  output logic       adj_en,
  output logic [2:0] adj_sel,
  output logic [3:0] adj_val,
  output logic       adj_wr,
  output logic       blink_on
);
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DW-1:0] TERM = DW'(HALF - 1);
  state_t state, nxt;
  logic rst_ev, pause_ev, adj_in, restart, wr_ev;
  logic [1:0] sel_q;
  logic [3:0] num_q;
  logic [DW-1:0] div;
  edge_rise u_rst_edge (.clk(clk), .rst_n(rst_n), .d(btn_reset), .rise(rst_ev));
  edge_rise u_pause_edge (.clk(clk), .rst_n(rst_n), .d(btn_pause), .rise(pause_ev));
  // Reset edge dominates everything, then adj_sw; pause edges only toggle RUN/PAUSE.
  always_comb begin
    nxt = rst_ev ? CLEAR :
          adj_sw ? ADJUST :
          (state == ADJUST || state == CLEAR) ? PAUSE :
          pause_ev ? ((state == RUN) ? PAUSE : RUN) : state;
    adj_in  = (nxt == ADJUST);
    restart = adj_in && (state != ADJUST || sel != sel_q);
    wr_ev   = restart || (adj_in && num != num_q);
  end
  // Outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= PAUSE;
      cnt_rst  <= 1'b1;
      paused   <= 1'b1;
      adj_en   <= 1'b0;
      adj_sel  <= ADJ_SEL_NONE;
      adj_val  <= '0;
      adj_wr   <= 1'b0;
      blink_on <= 1'b1;
      div      <= '0;
      sel_q    <= '0;
      num_q    <= '0;
    end else begin
      state   <= nxt;
      cnt_rst <= (nxt == CLEAR);
      paused  <= (nxt != RUN);
      adj_en  <= adj_in;
      adj_sel <= adj_in ? {1'b0, sel} : ADJ_SEL_NONE;
      adj_val <= clamp_digit(sel, num);
      adj_wr  <= wr_ev;
      sel_q   <= sel;
      num_q   <= num;
      if (!adj_in || restart) begin
        div      <= '0;
        blink_on <= 1'b1;
      end else if (div == TERM) begin
        div      <= '0;
        blink_on <= ~blink_on;
      end else div <= div + 1'b1;
    end
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scenario and randomized checks of stopwatch_ctrl against a rule-level model
module tb_stopwatch_ctrl;
  localparam int HALF = 4;
  localparam int M_RUN = 0, M_PAUSE = 1, M_ADJ = 2, M_CLEAR = 3;
  logic clk = 1'b0;
  logic rst_n, btn_reset, btn_pause, adj_sw;
  logic [1:0] sel;
  logic [3:0] num;
  logic cnt_rst, paused, adj_en, adj_wr, blink_on;
  logic [2:0] adj_sel;
  logic [3:0] adj_val;
  int errors = 0, checks = 0;
  int m_mode, m_since;
  logic m_pr, m_pp;
  logic [1:0] m_psel;
  logic [3:0] m_pnum;
  logic e_cnt_rst, e_paused, e_adj_en, e_adj_wr, e_blink;
  logic [2:0] e_adj_sel;
  logic [3:0] e_adj_val;

  stopwatch_ctrl #(.CLK_HZ(8), .BLINK_HZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .btn_reset(btn_reset), .btn_pause(btn_pause),
    .adj_sw(adj_sw), .sel(sel), .num(num), .cnt_rst(cnt_rst), .paused(paused),
    .adj_en(adj_en), .adj_sel(adj_sel), .adj_val(adj_val), .adj_wr(adj_wr),
    .blink_on(blink_on)
  );

  always #5 clk = ~clk;

  // One clock edge: advance the reference model from the inputs seen at the edge, then settle.
  task automatic cyc();
    logic re, pe, entry, sch;
    int old, lim;
    @(posedge clk);
    if (!rst_n) begin
      m_mode = M_PAUSE; m_pr = 1'b1; m_pp = 1'b1; m_since = 0;
      e_cnt_rst = 1'b1; e_paused = 1'b1; e_adj_en = 1'b0; e_adj_sel = 3'd5;
      e_adj_val = 4'd0; e_adj_wr = 1'b0; e_blink = 1'b1;
    end else begin
      re = btn_reset && !m_pr;
      pe = btn_pause && !m_pp;
      old = m_mode;
      case (old)
        M_RUN:   m_mode = adj_sw ? M_ADJ : (pe ? M_PAUSE : M_RUN);
        M_PAUSE: m_mode = adj_sw ? M_ADJ : (pe ? M_RUN : M_PAUSE);
        default: m_mode = adj_sw ? M_ADJ : M_PAUSE;
      endcase
      if (re) m_mode = M_CLEAR;
      entry = (m_mode == M_ADJ) && (old != M_ADJ);
      sch = (sel != m_psel);
      lim = sel[0] ? 5 : 9;
      e_cnt_rst = (m_mode == M_CLEAR);
      e_paused = (m_mode != M_RUN);
      e_adj_en = (m_mode == M_ADJ);
      e_adj_sel = e_adj_en ? {1'b0, sel} : 3'd5;
      e_adj_val = (int'(num) > lim) ? 4'(lim) : num;
      e_adj_wr = e_adj_en && (entry || sch || num != m_pnum);
      if (!e_adj_en || entry || sch) m_since = 0;
      else m_since++;
      e_blink = ((m_since / HALF) % 2) == 0;
      m_pr = btn_reset; m_pp = btn_pause;
    end
    m_psel = sel; m_pnum = num;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_reset = 1'b0; btn_pause = 1'b1; adj_sw = 1'b0; sel = 2'd0; num = 4'd0;
    cyc(); cyc();
    if ({cnt_rst, paused, adj_en, adj_wr, blink_on} !== 5'b11001) begin errors++;
      $display("FAIL reset_flags got=%b exp=11001", {cnt_rst, paused, adj_en, adj_wr, blink_on}); end
    checks++;
    if (adj_sel !== 3'd5 || adj_val !== 4'd0) begin errors++;
      $display("FAIL reset_adj got sel=%0d val=%0d exp sel=5 val=0", adj_sel, adj_val); end
    checks++;
    rst_n = 1'b1;
    cyc();
    if (cnt_rst !== 1'b0 || paused !== 1'b1) begin errors++;
      $display("FAIL reset_release got cnt_rst=%b paused=%b exp 0 1", cnt_rst, paused); end
    checks++;
  endtask

  task automatic test_pause_held();
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (paused !== 1'b1) begin errors++;
        $display("FAIL held_pause cyc=%0d got paused=%b exp 1", i, paused); end
      checks++;
    end
    btn_pause = 1'b0; cyc();
    btn_pause = 1'b1; cyc();
    if (paused !== 1'b0) begin errors++;
      $display("FAIL repress_run got paused=%b exp 0", paused); end
    checks++;
    btn_pause = 1'b0; cyc();
  endtask

  task automatic test_pause_toggle();
    btn_reset = 1'b1; cyc(); btn_reset = 1'b0; cyc();
    btn_pause = 1'b1; cyc();
    if (paused !== 1'b0) begin errors++;
      $display("FAIL toggle_first got paused=%b exp 0", paused); end
    checks++;
    btn_pause = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (paused !== 1'b0) begin errors++;
        $display("FAIL toggle_hold cyc=%0d got paused=%b exp 0", i, paused); end
      checks++;
    end
    btn_pause = 1'b1; cyc();
    if (paused !== 1'b1) begin errors++;
      $display("FAIL toggle_second got paused=%b exp 1", paused); end
    checks++;
    btn_pause = 1'b0; cyc();
  endtask

  task automatic test_same_cycle();
    btn_pause = 1'b1; cyc(); btn_pause = 1'b0; cyc();
    if (paused !== 1'b0) begin errors++;
      $display("FAIL same_pre_run got paused=%b exp 0", paused); end
    checks++;
    btn_reset = 1'b1; btn_pause = 1'b1; cyc();
    if (cnt_rst !== 1'b1 || paused !== 1'b1) begin errors++;
      $display("FAIL same_clear got cnt_rst=%b paused=%b exp 1 1", cnt_rst, paused); end
    checks++;
    btn_reset = 1'b0; btn_pause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      if (cnt_rst !== 1'b0 || paused !== 1'b1 || adj_en !== 1'b0) begin errors++;
        $display("FAIL same_after cyc=%0d got cnt_rst=%b paused=%b adj_en=%b exp 0 1 0", i, cnt_rst, paused, adj_en); end
      checks++;
    end
  endtask

  task automatic test_adjust_write();
    int wr_cnt;
    adj_sw = 1'b1; sel = 2'd1; num = 4'd8; cyc();
    if (adj_en !== 1'b1 || adj_sel !== 3'd1 || adj_val !== 4'd5 || adj_wr !== 1'b1) begin errors++;
      $display("FAIL adj_entry got en=%b sel=%0d val=%0d wr=%b exp 1 1 5 1", adj_en, adj_sel, adj_val, adj_wr); end
    checks++;
    wr_cnt = 0;
    for (int i = 0; i < 5; i++) begin cyc(); wr_cnt += int'(adj_wr); end
    if (wr_cnt != 0) begin errors++;
      $display("FAIL adj_wr_quiet got pulses=%0d exp 0", wr_cnt); end
    checks++;
    num = 4'd3; cyc();
    if (adj_wr !== 1'b1 || adj_val !== 4'd3) begin errors++;
      $display("FAIL adj_num_change got wr=%b val=%0d exp 1 3", adj_wr, adj_val); end
    checks++;
    cyc();
    if (adj_wr !== 1'b0) begin errors++;
      $display("FAIL adj_wr_single got wr=%b exp 0", adj_wr); end
    checks++;
  endtask

  task automatic test_blink();
    logic exp_b;
    sel = 2'd2; num = 4'd7; cyc();
    if (blink_on !== 1'b1 || adj_wr !== 1'b1 || adj_val !== 4'd7) begin errors++;
      $display("FAIL blink_restart got blink=%b wr=%b val=%0d exp 1 1 7", blink_on, adj_wr, adj_val); end
    checks++;
    for (int i = 1; i < 11; i++) begin
      cyc();
      exp_b = ((i / 4) % 2) == 0;
      if (blink_on !== exp_b) begin errors++;
        $display("FAIL blink_period i=%0d got=%b exp=%b", i, blink_on, exp_b); end
      checks++;
    end
    sel = 2'd3; cyc();
    if (blink_on !== 1'b1 || adj_val !== 4'd5) begin errors++;
      $display("FAIL blink_sel_restart got blink=%b val=%0d exp 1 5", blink_on, adj_val); end
    checks++;
    for (int i = 1; i < 5; i++) cyc();
    if (blink_on !== 1'b0) begin errors++;
      $display("FAIL blink_after_restart got=%b exp=0", blink_on); end
    checks++;
    adj_sw = 1'b0; cyc();
    if (paused !== 1'b1 || adj_en !== 1'b0 || adj_sel !== 3'd5 || blink_on !== 1'b1 || adj_wr !== 1'b0) begin errors++;
      $display("FAIL adj_exit got paused=%b en=%b sel=%0d blink=%b wr=%b exp 1 0 5 1 0", paused, adj_en, adj_sel, blink_on, adj_wr); end
    checks++;
  endtask

  task automatic test_adjust_reset();
    adj_sw = 1'b1; sel = 2'd0; num = 4'd12; cyc(); cyc();
    btn_reset = 1'b1; cyc();
    if (cnt_rst !== 1'b1 || adj_en !== 1'b0) begin errors++;
      $display("FAIL adj_clear got cnt_rst=%b en=%b exp 1 0", cnt_rst, adj_en); end
    checks++;
    btn_reset = 1'b0; cyc();
    if (cnt_rst !== 1'b0 || adj_en !== 1'b1 || adj_wr !== 1'b1 || adj_val !== 4'd9) begin errors++;
      $display("FAIL adj_reentry got cnt_rst=%b en=%b wr=%b val=%0d exp 0 1 1 9", cnt_rst, adj_en, adj_wr, adj_val); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      btn_pause = 1'b1; cyc(); btn_pause = 1'b0; cyc();
      if (adj_en !== 1'b1 || paused !== 1'b1 || adj_wr !== 1'b0) begin errors++;
        $display("FAIL adj_pause_ignored i=%0d got en=%b paused=%b wr=%b exp 1 1 0", i, adj_en, paused, adj_wr); end
      checks++;
    end
    rst_n = 1'b0; cyc();
    if (adj_en !== 1'b0 || cnt_rst !== 1'b1 || adj_sel !== 3'd5) begin errors++;
      $display("FAIL adj_abort got en=%b cnt_rst=%b sel=%0d exp 0 1 5", adj_en, cnt_rst, adj_sel); end
    checks++;
    rst_n = 1'b1; adj_sw = 1'b0; cyc();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 9) == 0) btn_reset = ~btn_reset;
      if ($urandom_range(0, 2) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 19) == 0) adj_sw = ~adj_sw;
      if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) num = 4'($urandom_range(0, 15));
      cyc();
      if (cnt_rst !== e_cnt_rst) begin errors++;
        $display("FAIL rnd_cnt_rst c=%0d got=%b exp=%b", c, cnt_rst, e_cnt_rst); end
      checks++;
      if (paused !== e_paused) begin errors++;
        $display("FAIL rnd_paused c=%0d got=%b exp=%b", c, paused, e_paused); end
      checks++;
      if (adj_en !== e_adj_en || adj_sel !== e_adj_sel) begin errors++;
        $display("FAIL rnd_adj c=%0d got en=%b sel=%0d exp en=%b sel=%0d", c, adj_en, adj_sel, e_adj_en, e_adj_sel); end
      checks++;
      if (adj_wr !== e_adj_wr) begin errors++;
        $display("FAIL rnd_adj_wr c=%0d got=%b exp=%b", c, adj_wr, e_adj_wr); end
      checks++;
      if (blink_on !== e_blink) begin errors++;
        $display("FAIL rnd_blink c=%0d got=%b exp=%b", c, blink_on, e_blink); end
      checks++;
      if ((e_adj_en || !rst_n) && adj_val !== e_adj_val) begin errors++;
        $display("FAIL rnd_adj_val c=%0d got=%0d exp=%0d", c, adj_val, e_adj_val); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_pause_held();
    test_pause_toggle();
    test_same_cycle();
    test_adjust_write();
    test_blink();
    test_adjust_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BLINK_HZ, default 2, meaning the adjust-digit blink rate in Hz (full on+off period).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, meaning the reset: synchronous and active-low.
REQ-005 SHALL have port btn_reset, input, 1 bit, meaning the debounced clear-button level.
REQ-006 SHALL have port btn_pause, input, 1 bit, meaning the debounced run/pause-button level.
REQ-007 SHALL have port adj_sw, input, 1 bit, meaning the adjust-mode switch level.
REQ-008 SHALL have port sel, input, 2 bits, meaning the digit position to adjust (0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens).
REQ-009 SHALL have port num, input, 4 bits, meaning the requested digit value.
REQ-010 SHALL have port cnt_rst, output, 1 bit, meaning the counter clear.
REQ-011 SHALL have port paused, output, 1 bit, meaning the counter hold.
REQ-012 SHALL have port adj_en, output, 1 bit, meaning adjust mode is active.
REQ-013 SHALL have port adj_sel, output, 3 bits, meaning the digit being adjusted; 5 = none.
REQ-014 SHALL have port adj_val, output, 4 bits, meaning the clamped digit value.
REQ-015 SHALL have port adj_wr, output, 1 bit, meaning a one-cycle digit-write strobe.
REQ-016 SHALL have port blink_on, output, 1 bit, meaning the display-enable for the selected digit.

Function
REQ-017 SHALL implement FSM states RUN, PAUSE, ADJUST, CLEAR; all outputs registered.
REQ-018 SHALL detect rising edges of btn_reset and btn_pause; one edge = one event; held levels produce no further events.
REQ-019 SHALL, on a btn_reset edge in any state, enter CLEAR; CLEAR lasts exactly 1 cycle with cnt_rst=1, then goes to ADJUST if adj_sw=1, else PAUSE.
REQ-020 SHALL, when btn_reset and btn_pause edges occur in the same cycle, honour reset and discard pause.
REQ-021 SHALL, on a btn_pause edge, toggle RUN->PAUSE and PAUSE->RUN, unless adj_sw=1.
REQ-022 SHALL, when adj_sw=1 in RUN or PAUSE, enter ADJUST next cycle.
REQ-023 SHALL ignore btn_pause in ADJUST.
REQ-024 SHALL, when adj_sw=0 in ADJUST, go to PAUSE.
REQ-025 SHALL set paused=1 in every state except RUN.
REQ-026 SHALL set adj_en=1 only in ADJUST.
REQ-027 SHALL set adj_sel={0,sel} in ADJUST, else 5.
REQ-028 SHALL clamp adj_val: sel=1 or 3 -> min(num,5); sel=0 or 2 -> min(num,9).
REQ-029 SHALL pulse adj_wr for 1 cycle on ADJUST entry and whenever sel or num differs from its previous-cycle value while in ADJUST; adj_wr SHALL never be asserted outside ADJUST.
REQ-030 SHALL hold blink_on=1 outside ADJUST; in ADJUST it toggles every CLK_HZ/(2*BLINK_HZ) cycles; the blink divider restarts and blink_on=1 on each ADJUST entry and each sel change.
REQ-031 SHALL size the divider as $clog2(CLK_HZ/(2*BLINK_HZ)) bits; wrap to 0 at terminal count, no overflow.

Reset
REQ-032 SHALL, while rst_n=0 at a clk edge, set state=PAUSE, cnt_rst=1, paused=1, adj_en=0, adj_sel=5, adj_val=0, adj_wr=0, blink_on=1, divider=0.
REQ-033 SHALL reset the edge-detector history registers to 1 so a button held through reset release produces no event.
REQ-034 SHALL, on the first cycle after rst_n rises, deassert cnt_rst and evaluate adj_sw normally.
REQ-035 SHALL, on reset asserted mid-ADJUST or mid-CLEAR, abort immediately to reset values.

Structure
REQ-036 SHALL place the state enum, the digit-position constants, ADJ_SEL_NONE=5, and the per-position max digit (9/5) in shared package stopwatch_pkg.
REQ-037 SHALL use one sub-module, edge_rise (1-bit registered rising-edge detector, reset history=1), instantiated twice.

Verification (CLK_HZ=8, BLINK_HZ=1: half-period 4 cycles)
REQ-038 SHALL cover: reset release with btn_pause held high -> state PAUSE, no RUN transition until release and re-press.
REQ-039 SHALL cover: btn_pause pulse, then a second pulse 10 cycles later -> paused 1->0 one cycle after the first edge, 0->1 after the second.
REQ-040 SHALL cover: btn_reset and btn_pause edges in the same cycle while RUN -> cnt_rst=1 for exactly 1 cycle, then PAUSE, paused=1.
REQ-041 SHALL cover: adj_sw=1, sel=1, num=8 -> adj_en=1, adj_sel=1, adj_val=5, one adj_wr pulse; then num=3 -> one further adj_wr pulse with adj_val=3.
REQ-042 SHALL cover: in ADJUST, blink_on toggles every 4 cycles; changing sel -> blink_on=1 and the count restarts; adj_sw=0 -> PAUSE, adj_sel=5, blink_on=1.
REQ-043 SHALL cover: in ADJUST, pulse btn_reset -> 1-cycle cnt_rst, return to ADJUST with an adj_wr pulse; btn_pause presses in ADJUST -> no state change.
